// File: rtl/aes_word_stream_if.sv
// Word-serial front/back end for a 128-bit AES core: gathers key/text words into
// 128-bit registers, strobes the core, then drains the ciphertext as words.
module aes_word_stream_if #(
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_key_upd,
    output logic              core_valid,
    output logic [127:0]      core_key,
    output logic [127:0]      core_plain,
    input  logic [127:0]      core_cypher,
    input  logic              core_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              busy,
    output logic              err
);

    localparam int unsigned   NW     = 128 / WORD_W;
    localparam int unsigned   CW     = $clog2(NW);
    localparam int unsigned   TW     = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_W = CW'(NW - 1);
    // Timeout fires on the WAIT cycle where the counter would step to TIMEOUT-1
    localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_TXT,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic          r_s_ready;
    logic          r_core_valid;
    logic          r_m_valid;
    logic          r_err;
    logic [127:0]  r_key;
    logic [127:0]  r_plain;
    logic [127:0]  r_cypher;
    logic [CW-1:0] r_wcnt;
    logic [TW-1:0] r_tcnt;

    logic          w_s_hs;
    logic          w_m_hs;
    logic [127:0]  w_key_shift;
    logic [127:0]  w_plain_shift;

    assign w_s_hs        = s_valid & r_s_ready;
    assign w_m_hs        = r_m_valid & m_ready;
    assign w_key_shift   = {r_key[127-WORD_W:0], s_data};
    assign w_plain_shift = {r_plain[127-WORD_W:0], s_data};

    assign s_ready    = r_s_ready;
    assign core_valid = r_core_valid;
    assign core_key   = r_key;
    assign core_plain = r_plain;
    assign m_valid    = r_m_valid;
    assign m_data     = r_cypher[127 -: WORD_W];
    assign busy       = (r_state != S_IDLE);
    assign err        = r_err;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_s_ready    <= 1'b0;
            r_core_valid <= 1'b0;
            r_m_valid    <= 1'b0;
            r_err        <= 1'b0;
            r_key        <= '0;
            r_plain      <= '0;
            r_cypher     <= '0;
            r_wcnt       <= '0;
            r_tcnt       <= '0;
        end else begin
            r_core_valid <= 1'b0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_s_ready <= 1'b1;
                    if (w_s_hs) begin
                        r_wcnt <= CW'(1);
                        if (s_key_upd) begin
                            r_key   <= w_key_shift;
                            r_state <= S_LOAD_KEY;
                        end else begin
                            r_plain <= w_plain_shift;
                            r_state <= S_LOAD_TXT;
                        end
                    end
                end
                S_LOAD_KEY: begin
                    if (w_s_hs) begin
                        r_key <= w_key_shift;
                        if (r_wcnt == LAST_W) begin
                            r_wcnt  <= '0;
                            r_state <= S_LOAD_TXT;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_LOAD_TXT: begin
                    if (w_s_hs) begin
                        r_plain <= w_plain_shift;
                        if (r_wcnt == LAST_W) begin
                            r_wcnt       <= '0;
                            r_s_ready    <= 1'b0;
                            r_core_valid <= 1'b1;
                            r_state      <= S_START;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (core_done) begin
                        r_cypher  <= core_cypher;
                        r_m_valid <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (r_tcnt == LAST_T) begin
                        r_err     <= 1'b1;
                        r_plain   <= '0;
                        r_s_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_m_hs) begin
                        r_cypher <= {r_cypher[127-WORD_W:0], {WORD_W{1'b0}}};
                        if (r_wcnt == LAST_W) begin
                            r_wcnt    <= '0;
                            r_m_valid <= 1'b0;
                            r_s_ready <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_word_stream_if.sv
// Directed bench for aes_word_stream_if: FIPS-197 vector, key reuse, backpressure,
// timeout, done/timeout tie and reset in mid-frame, with a scripted core model.
module tb_aes_word_stream_if;

    localparam int unsigned W  = 32;
    localparam int unsigned TO = 16;

    localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FTXT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          CLK = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_key_upd = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          core_done = 1'b0;
    logic [127:0]  core_cypher = '0;
    logic          m_ready = 1'b0;
    logic          s_ready, core_valid, m_valid, busy, err;
    logic [127:0]  core_key, core_plain;
    logic [W-1:0]  m_data;

    int total = 0;
    int bad = 0;
    int cv_cnt = 0;

    aes_word_stream_if #(.WORD_W(W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_key_upd(s_key_upd),
        .core_valid(core_valid), .core_key(core_key), .core_plain(core_plain),
        .core_cypher(core_cypher), .core_done(core_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (core_valid === 1'b1) cv_cnt++;

    task automatic send_word(input logic [W-1:0] d, input logic k);
        logic rdy;
        bit   ok;
        ok = 0;
        s_data = d; s_key_upd = k; s_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            rdy = s_ready;
            @(negedge CLK);
            if (rdy === 1'b1) begin ok = 1; break; end
        end
        s_valid = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL send_word %h: accepted=0 required=1", d); end
    endtask

    // key is both the frame content (when ku=1) and the expected core_key afterwards
    task automatic send_frame(input logic ku, input logic [127:0] key, input logic [127:0] txt,
                              input bit gap);
        if (ku) begin
            for (int i = 0; i < 4; i++) begin
                send_word(key[127-32*i -: 32], (i == 0));
                if (gap) @(negedge CLK);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_word(txt[127-32*i -: 32], ku ? 1'b0 : (i != 0));
            if (gap && i != 3) @(negedge CLK);
        end
        total++;
        if (core_valid !== 1'b1 || core_key !== key || core_plain !== txt) begin
            bad++;
            $display("FAIL frame_start: core_valid=%b key=%h plain=%h required 1 %h %h",
                     core_valid, core_key, core_plain, key, txt);
        end
    endtask

    task automatic core_reply(input int dly, input logic [127:0] ct);
        @(negedge CLK);
        total++;
        if (s_ready !== 1'b0 || busy !== 1'b1 || core_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_state: s_ready=%b busy=%b core_valid=%b required 0 1 0",
                     s_ready, busy, core_valid);
        end
        repeat (dly - 1) @(negedge CLK);
        core_cypher = ct; core_done = 1'b1;
        @(negedge CLK);
        core_done = 1'b0; core_cypher = ~ct;
        total++;
        if (m_valid !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL done_latency: m_valid=%b err=%b required 1 0", m_valid, err);
        end
    endtask

    task automatic drain(input logic [127:0] ct, input int stall_w, input int stall_n);
        logic [W-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = ct[127-32*i -: 32];
            total++;
            if (m_valid !== 1'b1 || m_data !== exp) begin
                bad++;
                $display("FAIL out_word%0d: m_valid=%b m_data=%h required 1 %h", i, m_valid, m_data, exp);
            end
            if (i == stall_w) begin
                repeat (stall_n) begin
                    @(negedge CLK);
                    total++;
                    if (m_valid !== 1'b1 || m_data !== exp || s_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_hold: m_valid=%b m_data=%h s_ready=%b required 1 %h 0",
                                 m_valid, m_data, s_ready, exp);
                    end
                end
            end
            m_ready = 1'b1;
            @(negedge CLK);
            m_ready = 1'b0;
        end
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_end: m_valid=%b busy=%b s_ready=%b required 0 0 1", m_valid, busy, s_ready);
        end
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if ({s_ready, core_valid, m_valid, busy, err} !== 5'b0 || m_data !== '0 ||
            core_key !== '0 || core_plain !== '0) begin
            bad++;
            $display("FAIL %s: ctl=%b m_data=%h key=%h plain=%h required all 0", tag,
                     {s_ready, core_valid, m_valid, busy, err}, m_data, core_key, core_plain);
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        check_all_zero("reset_values");
        rst_n = 1'b1;
        @(negedge CLK);
        total++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_ready: s_ready=%b busy=%b required 1 0", s_ready, busy);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  mv_seen;
        n = 0; mv_seen = 0;
        send_frame(1'b0, '0, FTXT, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            n++;
            if (m_valid === 1'b1) mv_seen = 1;
            if (err === 1'b1) break;
        end
        total++;
        if (n != TO || err !== 1'b1) begin
            bad++; $display("FAIL timeout_cycles: err=%b after %0d cycles required 1 after %0d", err, n, TO);
        end
        total++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || core_plain !== '0 || mv_seen) begin
            bad++;
            $display("FAIL timeout_state: busy=%b s_ready=%b plain=%h m_valid_seen=%b required 0 1 0 0",
                     busy, s_ready, core_plain, mv_seen);
        end
        @(negedge CLK);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL err_pulse: err=%b required 0", err); end
    endtask

    task automatic test_fips();
        int c0;
        c0 = cv_cnt;
        send_frame(1'b1, FKEY, FTXT, 0);
        core_reply(3, FCT);
        drain(FCT, -1, 0);
        total++;
        if (cv_cnt != c0 + 1) begin
            bad++; $display("FAIL core_valid_pulses: got=%0d required=1", cv_cnt - c0);
        end
    endtask

    task automatic test_key_reuse();
        send_frame(1'b0, FKEY, FTXT, 0);
        core_reply(2, FCT);
        drain(FCT, -1, 0);
        total++;
        if (core_key !== FKEY) begin bad++; $display("FAIL key_kept: key=%h required %h", core_key, FKEY); end
    endtask

    task automatic test_backpressure();
        send_frame(1'b0, FKEY, FTXT, 1);
        core_reply(4, FCT);
        drain(FCT, 1, 5);
    endtask

    task automatic test_tie();
        send_frame(1'b0, FKEY, FTXT, 0);
        core_reply(TO - 1, FCT);
        drain(FCT, 3, 2);
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL tie_err: err=%b required 0", err); end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) send_word(FKEY[127-32*i -: 32], (i == 0));
        send_word(32'h00112233, 1'b0);
        send_word(32'h44556677, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge CLK);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge CLK);
        send_frame(1'b1, FKEY, FTXT, 0);
        core_reply(1, FCT);
        drain(FCT, -1, 0);
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_fips();
        test_key_reuse();
        test_backpressure();
        test_tie();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_word_stream_if.md
Name: aes_word_stream_if

Overview:
- Word-serial front/back end for the 128-bit AES core.
- Assembles key and plaintext words from a valid/ready input stream into 128-bit registers and pulses the core's start strobe.
- Waits for the core's done, captures the 128-bit ciphertext, and drains it as words on a valid/ready output stream.
- Sits directly between the system bus adapter and the AES core.

Parameters:
- WORD_W, 32, stream word width; legal values 8, 16, 32, 64; NW = 128/WORD_W words per block.
- TIMEOUT, 64, max cycles from core start to core_done before abort; legal range 16..1023.

Ports:
- CLK  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  WORD_W  input word.
- s_key_upd  in  1  sampled on first accepted word of a frame: 1 = frame is NW key words then NW text words; 0 = NW text words, stored key reused.
- core_valid  out  1  one-cycle start strobe to the AES core.
- core_key  out  128  key register, driven continuously.
- core_plain  out  128  plaintext register, driven continuously.
- core_cypher  in  128  ciphertext from the core.
- core_done  in  1  core completion; ciphertext valid in the same cycle.
- m_valid  out  1  output word valid.
- m_ready  in  1  output word consumed when m_valid && m_ready.
- m_data  out  WORD_W  output word.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE, key/plain/cypher regs=0, counters=0. s_ready=0, core_valid=0, m_valid=0, m_data=0, busy=0, err=0.
- Word order: MSB first. Word i of a block fills bits [127-i*WORD_W -: WORD_W].
- IDLE:
  - s_ready=1.
  - On first accepted word: latch s_key_upd. Go to LOAD_KEY (word stored as key word 0) if 1, else LOAD_TXT (word stored as text word 0).
- LOAD_KEY:
  - s_ready=1. Shift accepted words into key reg.
  - After word NW-1, go to LOAD_TXT with word count cleared.
  - Key reg changes only in this state; core_key is therefore stable for the whole operation.
- LOAD_TXT:
  - s_ready=1. Shift accepted words into plain reg.
  - After word NW-1, go to START.
  - s_key_upd on non-first words is ignored.
- START:
  - s_ready=0. core_valid=1 for exactly this cycle.
  - Clear timeout counter; next state WAIT.
- WAIT:
  - s_ready=0. Counter increments each cycle.
  - core_done=1: capture core_cypher into cypher reg, go to DRAIN.
  - Counter reaches TIMEOUT-1 with core_done=0: err=1 for one cycle, go to IDLE; key reg retained, plain reg cleared.
  - core_done and the final count in the same cycle: done wins, no err.
  - core_done outside WAIT is ignored.
- DRAIN:
  - m_valid=1, m_data = current word of cypher reg.
  - m_data and m_valid held stable while m_ready=0.
  - Each handshake advances the word index.
  - Handshake on word NW-1: next cycle m_valid=0 and state=IDLE.
  - s_ready=0 throughout, so no new frame overlaps output.
- Throughput: one word per cycle on both streams when unstalled.
- Latency: last input word accepted -> core_valid 1 cycle later; core_done -> m_valid high next cycle.
- Back-to-back: IDLE accepts a new frame in the cycle after the final output handshake.
- Key before any key frame: a reuse frame (s_key_upd=0) after reset uses key=0.
- Reset mid-operation: immediate return to reset values. Partial frames and a pending cypher are discarded, and no err pulse is generated.

Test Plan:
- FIPS-197 vector, WORD_W=32, s_key_upd=1: key words 00010203,04050607,08090a0b,0c0d0e0f, then text 00112233,44556677,8899aabb,ccddeeff -> exactly one core_valid pulse; output words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a; busy falls after the 4th output handshake.
- Key reuse: immediately repeat the same text with s_key_upd=0 (4 words only) -> same 69c4e0d8.. output; core_key unchanged throughout.
- Backpressure: m_ready low for 5 cycles on word 1, and s_valid toggled every other cycle on input -> m_data holds 6a7b0430 while stalled; no words lost or duplicated; s_ready=0 during WAIT/DRAIN.
- Timeout: core model never asserts core_done, TIMEOUT=16 -> err pulses exactly 16 cycles after core_valid; state returns to IDLE; m_valid never rises.
- Done/timeout tie: core_done asserted on cycle TIMEOUT-1 of WAIT -> no err; ciphertext drained normally.
- Reset mid-frame: assert rst_n=0 after 2 text words, then release and send a full FIPS frame -> all outputs 0 during reset; correct ciphertext after release; no stale words emitted.
